// File: rtl/segre_pkg.sv
// Shared word/line geometry, memory-op types and arbiter state encoding
// for the segre data cache.
package segre_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int FILL_BEATS = 4;
  localparam int LINE_SIZE  = WORD_SIZE * FILL_BEATS;
  localparam int BEAT_W     = $clog2(FILL_BEATS);

  localparam int                  STARVE_W     = 3;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 3'd4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10
  } arb_state_e;

endpackage

// File: rtl/segre_dcache_port_arbiter.sv
// Single-port data cache arbiter: line refills, store-buffer drains and load
// lookups share one registered cache port command.
module segre_dcache_port_arbiter
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 fill_req_i,
  input  logic [WORD_SIZE-1:0] fill_addr_i,
  input  logic [LINE_SIZE-1:0] fill_data_i,
  input  logic                 sb_req_i,
  input  logic [WORD_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  memop_data_type_e     sb_type_i,
  input  logic                 sb_urgent_i,
  input  logic                 ld_req_i,
  input  logic [WORD_SIZE-1:0] ld_addr_i,
  input  memop_data_type_e     ld_type_i,
  output logic                 fill_gnt_o,
  output logic                 sb_gnt_o,
  output logic                 ld_gnt_o,
  output logic                 ld_stall_o,
  output logic                 cache_req_o,
  output logic                 cache_we_o,
  output logic                 cache_fill_o,
  output logic [WORD_SIZE-1:0] cache_addr_o,
  output logic [WORD_SIZE-1:0] cache_data_o,
  output memop_data_type_e     cache_type_o
);

  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(FILL_BEATS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  arb_state_e                           state_q;
  logic [BEAT_W-1:0]                    beat_q;
  logic [STARVE_W-1:0]                  starve_q;
  logic                                 starved;
  logic                                 fill_write;
  logic [FILL_BEATS-1:0][WORD_SIZE-1:0] fill_words;
  logic [WORD_SIZE-1:0]                 fill_addr;

  assign starved    = (starve_q >= STARVE_LIMIT);
  assign fill_words = fill_data_i;
  assign fill_addr  = fill_addr_i + WORD_SIZE'({beat_q, 2'b00});
  assign ld_stall_o = ld_req_i && !ld_gnt_o;

  // A drain whose store buffer has emptied arbitrates like ARB in the same
  // cycle, so a waiting refill starts without a bubble.
  always_comb begin
    fill_gnt_o = 1'b0;
    sb_gnt_o   = 1'b0;
    ld_gnt_o   = 1'b0;
    fill_write = 1'b0;
    if (!rsn_i) begin
      if (state_q == FILL) begin
        fill_write = 1'b1;
        fill_gnt_o = (beat_q == LAST_BEAT);
      end else if (state_q == DRAIN && sb_req_i) begin
        sb_gnt_o = 1'b1;
      end else if (fill_req_i) begin
        fill_write = 1'b1;
      end else if (sb_req_i && (sb_urgent_i || starved)) begin
        sb_gnt_o = 1'b1;
      end else if (ld_req_i) begin
        ld_gnt_o = 1'b1;
      end else if (sb_req_i) begin
        sb_gnt_o = 1'b1;
      end
    end
  end

  // The refill grant cycle already writes beat 0, so FILL resumes at beat 1.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q      <= ARB;
      beat_q       <= '0;
      starve_q     <= '0;
      cache_req_o  <= 1'b0;
      cache_we_o   <= 1'b0;
      cache_fill_o <= 1'b0;
      cache_addr_o <= '0;
      cache_data_o <= '0;
      cache_type_o <= BYTE;
    end else begin
      if (state_q == FILL) begin
        if (beat_q == LAST_BEAT) begin
          state_q <= ARB;
          beat_q  <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end else if (fill_write) begin
        state_q <= FILL;
        beat_q  <= BEAT_W'(1);
      end else if (sb_gnt_o && sb_urgent_i) begin
        state_q <= DRAIN;
      end else begin
        state_q <= ARB;
      end

      if (sb_gnt_o) begin
        starve_q <= '0;
      end else if (state_q == ARB && sb_req_i && starve_q != STARVE_MAX) begin
        starve_q <= starve_q + 1'b1;
      end

      cache_req_o  <= fill_write || sb_gnt_o || ld_gnt_o;
      cache_we_o   <= fill_write || sb_gnt_o;
      cache_fill_o <= fill_write;
      if (fill_write) begin
        cache_addr_o <= fill_addr;
        cache_data_o <= fill_words[beat_q];
        cache_type_o <= WORD;
      end else if (sb_gnt_o) begin
        cache_addr_o <= sb_addr_i;
        cache_data_o <= sb_data_i;
        cache_type_o <= sb_type_i;
      end else if (ld_gnt_o) begin
        cache_addr_o <= ld_addr_i;
        cache_data_o <= '0;
        cache_type_o <= ld_type_i;
      end else begin
        cache_addr_o <= '0;
        cache_data_o <= '0;
        cache_type_o <= BYTE;
      end
    end
  end

  // A refill must stay requested until its final beat is granted.
  fill_held_during_fill : assert property (
    @(posedge clk_i) disable iff (rsn_i) (state_q == FILL) |-> fill_req_i
  );

endmodule

// File: tb/tb_segre_dcache_port_arbiter.sv
// Scoreboard bench for the dcache port arbiter: each cycle queues the command
// the cache port must show one cycle later and checks the grants directly.
module tb_segre_dcache_port_arbiter;
  import segre_pkg::*;

  typedef enum int {K_NONE, K_RST, K_FILL, K_SB, K_LD} kind_e;

  typedef struct {
    string                tag;
    kind_e                kind;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e     typ;
  } exp_t;

  logic                 clk_i = 1'b0;
  logic                 rsn_i;
  logic                 fill_req_i;
  logic [WORD_SIZE-1:0] fill_addr_i;
  logic [LINE_SIZE-1:0] fill_data_i;
  logic                 sb_req_i;
  logic [WORD_SIZE-1:0] sb_addr_i;
  logic [WORD_SIZE-1:0] sb_data_i;
  memop_data_type_e     sb_type_i;
  logic                 sb_urgent_i;
  logic                 ld_req_i;
  logic [WORD_SIZE-1:0] ld_addr_i;
  memop_data_type_e     ld_type_i;
  logic                 fill_gnt_o, sb_gnt_o, ld_gnt_o, ld_stall_o;
  logic                 cache_req_o, cache_we_o, cache_fill_o;
  logic [WORD_SIZE-1:0] cache_addr_o, cache_data_o;
  memop_data_type_e     cache_type_o;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  segre_dcache_port_arbiter dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .fill_req_i(fill_req_i), .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i),
    .sb_req_i(sb_req_i), .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i),
    .sb_type_i(sb_type_i), .sb_urgent_i(sb_urgent_i),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
    .fill_gnt_o(fill_gnt_o), .sb_gnt_o(sb_gnt_o), .ld_gnt_o(ld_gnt_o),
    .ld_stall_o(ld_stall_o),
    .cache_req_o(cache_req_o), .cache_we_o(cache_we_o), .cache_fill_o(cache_fill_o),
    .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o), .cache_type_o(cache_type_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WORD_SIZE-1:0] fillWord(input int beat);
    return 32'hDDDD0000 + WORD_SIZE'(beat);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic compareCommand(input exp_t e);
    checkOutput({e.tag, ".req"}, 64'(cache_req_o), (e.kind == K_NONE || e.kind == K_RST) ? 64'd0 : 64'd1);
    if (e.kind != K_NONE) begin
      checkOutput({e.tag, ".we"}, 64'(cache_we_o),
                  (e.kind == K_FILL || e.kind == K_SB) ? 64'd1 : 64'd0);
      checkOutput({e.tag, ".fill"}, 64'(cache_fill_o), (e.kind == K_FILL) ? 64'd1 : 64'd0);
      checkOutput({e.tag, ".addr"}, 64'(cache_addr_o), 64'(e.addr));
      checkOutput({e.tag, ".data"}, 64'(cache_data_o), 64'(e.data));
      if (e.kind != K_FILL)
        checkOutput({e.tag, ".type"}, 64'(cache_type_o), 64'(e.typ));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic expFill, input logic expSb,
                               input logic expLd, input kind_e kind, input int beat);
    exp_t e;
    @(negedge clk_i);
    if (scoreboard.size() > 0) compareCommand(scoreboard.pop_front());
    checkOutput({tag, ".fill_gnt"}, 64'(fill_gnt_o), 64'(expFill));
    checkOutput({tag, ".sb_gnt"}, 64'(sb_gnt_o), 64'(expSb));
    checkOutput({tag, ".ld_gnt"}, 64'(ld_gnt_o), 64'(expLd));
    checkOutput({tag, ".ld_stall"}, 64'(ld_stall_o), 64'(ld_req_i && !expLd));
    e.tag  = tag;
    e.kind = kind;
    e.addr = '0;
    e.data = '0;
    e.typ  = BYTE;
    case (kind)
      K_FILL: begin
        e.addr = fill_addr_i + WORD_SIZE'(4 * beat);
        e.data = fillWord(beat);
        e.typ  = WORD;
      end
      K_SB: begin
        e.addr = sb_addr_i;
        e.data = sb_data_i;
        e.typ  = sb_type_i;
      end
      K_LD: begin
        e.addr = ld_addr_i;
        e.typ  = ld_type_i;
      end
      default: ;
    endcase
    scoreboard.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearReqs();
    fill_req_i  = 1'b0;
    sb_req_i    = 1'b0;
    sb_urgent_i = 1'b0;
    ld_req_i    = 1'b0;
  endtask

  initial begin
    rsn_i       = 1'b1;
    fill_addr_i = '0;
    sb_addr_i   = '0;
    sb_data_i   = '0;
    sb_type_i   = BYTE;
    ld_addr_i   = '0;
    ld_type_i   = BYTE;
    clearReqs();
    for (int b = 0; b < 4; b++) fill_data_i[b*32 +: 32] = fillWord(b);

    // Reset holds every grant low while still reporting load stalls.
    ld_req_i = 1'b1; ld_addr_i = 32'h1C0; ld_type_i = WORD; sb_req_i = 1'b1;
    applyStimulus("reset0", 0, 0, 0, K_RST, 0);
    sb_req_i = 1'b0;
    applyStimulus("reset1", 0, 0, 0, K_RST, 0);
    rsn_i = 1'b0;

    ld_addr_i = 32'h100; ld_type_i = WORD;
    applyStimulus("ld_only", 0, 0, 1, K_LD, 0);
    clearReqs();
    applyStimulus("idle0", 0, 0, 0, K_NONE, 0);

    // Refill blocks a load for four write cycles, then the load goes.
    fill_req_i = 1'b1; fill_addr_i = 32'h200;
    ld_req_i = 1'b1; ld_addr_i = 32'h104; ld_type_i = HALF;
    for (int b = 0; b < 4; b++)
      applyStimulus($sformatf("fill_ld_b%0d", b), b == 3, 0, 0, K_FILL, b);
    fill_req_i = 1'b0;
    applyStimulus("ld_after_fill", 0, 0, 1, K_LD, 0);
    clearReqs();
    applyStimulus("idle1", 0, 0, 0, K_NONE, 0);

    // Loads beat a relaxed store until it has waited four arbitration cycles.
    sb_req_i = 1'b1; sb_addr_i = 32'h300; sb_data_i = 32'hCAFE0000; sb_type_i = WORD;
    ld_req_i = 1'b1; ld_addr_i = 32'h140; ld_type_i = BYTE;
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("starve_ld%0d", i), 0, 0, 1, K_LD, 0);
    applyStimulus("starve_sb", 0, 1, 0, K_SB, 0);
    sb_addr_i = 32'h304; sb_data_i = 32'hCAFE0001;
    applyStimulus("starve_ld_resume", 0, 0, 1, K_LD, 0);
    ld_req_i = 1'b0;
    applyStimulus("sb_alone", 0, 1, 0, K_SB, 0);
    clearReqs();
    applyStimulus("idle2", 0, 0, 0, K_NONE, 0);

    // Urgent drain of three entries finishes before a refill raised mid-drain.
    sb_req_i = 1'b1; sb_urgent_i = 1'b1; sb_type_i = HALF;
    for (int i = 0; i < 3; i++) begin
      sb_addr_i = 32'h600 + WORD_SIZE'(4 * i);
      sb_data_i = 32'hA5A50000 + WORD_SIZE'(i);
      if (i == 1) begin
        fill_req_i  = 1'b1;
        fill_addr_i = 32'h400;
      end
      applyStimulus($sformatf("drain%0d", i), 0, 1, 0, K_SB, 0);
    end
    sb_req_i = 1'b0; sb_urgent_i = 1'b0;
    for (int b = 0; b < 4; b++)
      applyStimulus($sformatf("fill_after_drain_b%0d", b), b == 3, 0, 0, K_FILL, b);
    clearReqs();
    applyStimulus("idle3", 0, 0, 0, K_NONE, 0);

    // Reset after two refill beats abandons the rest of the line.
    fill_req_i = 1'b1; fill_addr_i = 32'h500;
    applyStimulus("rst_fill_b0", 0, 0, 0, K_FILL, 0);
    applyStimulus("rst_fill_b1", 0, 0, 0, K_FILL, 1);
    rsn_i = 1'b1; fill_req_i = 1'b0;
    ld_req_i = 1'b1; ld_addr_i = 32'h180; ld_type_i = WORD;
    applyStimulus("rst_mid_fill", 0, 0, 0, K_RST, 0);
    rsn_i = 1'b0;
    applyStimulus("ld_after_rst", 0, 0, 1, K_LD, 0);
    clearReqs();
    applyStimulus("idle_end", 0, 0, 0, K_NONE, 0);

    while (scoreboard.size() > 0) begin
      @(negedge clk_i);
      compareCommand(scoreboard.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
